alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Command-side initiator for the 4-bit combinational ALU. It accepts operation commands over a valid/ready interface and drives the ALU operand, control and flag-in inputs from registers. It captures the ALU result and flag, then returns them over a valid/ready response interface. It also provides an accumulator chaining mode and status counters, so a testbench or a small control FSM can run ALU programs without timing the combinational ALU directly.

Parameters:
ANCHO, 4, operand/result width; must match the attached ALU instance.
CNT_W, 8, width of the op and error status counters.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  sequencer accepts command this cycle.
cmd_op  input  4  ALU operation code. Legal codes are 0x0–0x9.
cmd_a  input  ANCHO  operand A.
cmd_b  input  ANCHO  operand B.
cmd_flag_in  input  1  value driven onto the ALU flag input.
cmd_chain  input  1  1 = use the accumulator instead of cmd_a as operand A.
alu_a  output  ANCHO  to ALU A.
alu_b  output  ANCHO  to ALU B.
alu_ctrl  output  4  to ALU control.
alu_flag_in  output  1  to ALU flag input.
alu_result  input  ANCHO  from ALU result.
alu_flags  input  1  from ALU flag.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer takes response.
rsp_result  output  ANCHO  captured result.
rsp_flag  output  1  captured flag; masked, see rules below.
rsp_flag_valid  output  1  1 when the op defines a flag (0x2, 0x6, 0x8, 0x9).
rsp_err  output  1  illegal opcode.
op_count  output  CNT_W  count of ALU ops issued.
err_count  output  CNT_W  count of illegal commands.

Behaviour:
- Reset: asynchronous, active-low (rst_n), single clock clk. All outputs, the accumulator and both counters go to 0. The FSM goes to IDLE. Any in-flight command is dropped without a response.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, a legal op registers alu_a (acc if cmd_chain, else cmd_a), alu_b, alu_ctrl and alu_flag_in, then moves to ISSUE.
  - An illegal op (0xA–0xF) skips ISSUE and moves to RESP with rsp_err=1, result=0, flag=0 and flag_valid=0. It increments err_count. alu_* outputs are unchanged.
- ISSUE:
  - Lasts exactly one cycle; cmd_ready=0.
  - At the end of the cycle, samples alu_result and alu_flags into the rsp registers.
  - rsp_flag = alu_flags & flag_valid; rsp_flag_valid is set for ops 0x2/0x6/0x8/0x9. The ALU flag output is not defined for the other ops, so it is never passed through for them.
  - acc <= alu_result; op_count increments.
  - Moves to RESP.
- RESP:
  - rsp_valid=1. All rsp_* are held stable until rsp_ready.
  - cmd_ready = rsp_ready. If rsp_ready and cmd_valid are both high, the response retires and the new command is accepted in the same cycle (next state ISSUE or RESP). If rsp_ready is high without cmd_valid, the next state is IDLE.
- Latency:
  - Legal op: command accept at cycle N gives rsp_valid at N+2.
  - Illegal op: rsp_valid at N+1.
  - Sustained throughput: one legal op per 2 cycles.
- alu_* outputs hold their last value outside ISSUE; the ALU is combinational, and stable inputs avoid glitches on shared nets.
- Chaining:
  - acc is updated only by legal ops; an illegal command leaves acc unchanged.
  - cmd_chain with an illegal op is still an error.
- Counters wrap modulo 2^CNT_W with no saturation.
- Widths: all datapath is ANCHO bits with no extension; the carry/borrow appears only in rsp_flag.
- Overlapping events: reset asserted during ISSUE or RESP wins over everything.

Decomposition:
- Shared package alu_pkg holds the opcode constants OP_AND=0 … OP_RSHIFT=9, OP_LAST=9, and the function op_has_flag(op). The ALU and this block both use them.
- No sub-module is needed. The sequencer is a single FSM plus registers, and the ALU is instantiated in the bench, not inside.

Test Plan:
- AND: op=0x0, a=0xC, b=0xA -> rsp_result=0x8, rsp_flag_valid=0, rsp_flag=0, rsp_valid at N+2, op_count=1.
- ADD with carry: op=0x2, a=0x9, b=0x8 -> rsp_result=0x1, rsp_flag=1, rsp_flag_valid=1.
- Chain: op=0x7 (XOR) a=0x5, b=0x3 -> 0x6, then op=0x1 chain=1 b=0x8 -> alu_a=0x6, rsp_result=0xE.
- Illegal op: op=0xB -> rsp_err=1 at N+1, result=0, err_count=1, acc and op_count unchanged.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0. Then assert rsp_ready with cmd_valid high -> same-cycle accept, next rsp two cycles later.
- Reset mid-ISSUE: drop rst_n during ISSUE -> all outputs 0 immediately, no response emitted after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcodes and flag rules shared by the 4-bit ALU and its command sequencer.
package alu_pkg;

    localparam logic [3:0] OP_AND    = 4'd0;
    localparam logic [3:0] OP_OR     = 4'd1;
    localparam logic [3:0] OP_ADD    = 4'd2;
    localparam logic [3:0] OP_NAND   = 4'd3;
    localparam logic [3:0] OP_NOR    = 4'd4;
    localparam logic [3:0] OP_NOT    = 4'd5;
    localparam logic [3:0] OP_SUB    = 4'd6;
    localparam logic [3:0] OP_XOR    = 4'd7;
    localparam logic [3:0] OP_LSHIFT = 4'd8;
    localparam logic [3:0] OP_RSHIFT = 4'd9;
    localparam logic [3:0] OP_LAST   = OP_RSHIFT;

    // Only arithmetic and shift ops define the ALU flag (carry, borrow or shifted-out bit).
    function automatic logic op_has_flag(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LSHIFT) || (op == OP_RSHIFT);
    endfunction

    // Codes above OP_LAST are reserved and answered with an error response.
    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Command/response front end for the combinational ALU: registers the ALU inputs,
// waits one cycle for the ALU to settle, captures result and flag, and returns them.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int ANCHO = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [ANCHO-1:0] cmd_a,
    input  logic [ANCHO-1:0] cmd_b,
    input  logic             cmd_flag_in,
    input  logic             cmd_chain,
    output logic [ANCHO-1:0] alu_a,
    output logic [ANCHO-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    output logic             alu_flag_in,
    input  logic [ANCHO-1:0] alu_result,
    input  logic             alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ANCHO-1:0] rsp_result,
    output logic             rsp_flag,
    output logic             rsp_flag_valid,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [ANCHO-1:0] acc_reg;
    logic             can_accept;
    logic             accept;
    logic             issue_has_flag;

    // Ready in IDLE, or in RESP when the current response retires this cycle; forced low in reset.
    assign can_accept     = (state_reg == S_IDLE) || ((state_reg == S_RESP) && rsp_ready);
    assign cmd_ready      = rst_n && can_accept;
    assign accept         = cmd_valid && can_accept;
    assign issue_has_flag = op_has_flag(alu_ctrl);

    // Sequencer FSM with all ALU-side and response-side outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            acc_reg        <= '0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_ctrl       <= '0;
            alu_flag_in    <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_result     <= '0;
            rsp_flag       <= 1'b0;
            rsp_flag_valid <= 1'b0;
            rsp_err        <= 1'b0;
            op_count       <= '0;
            err_count      <= '0;
        end else begin
            case (state_reg)
                S_ISSUE: begin
                    // ALU inputs have been stable for a full cycle; capture its outputs.
                    // The flag is masked for ops that leave it undefined.
                    rsp_result     <= alu_result;
                    rsp_flag       <= alu_flags & issue_has_flag;
                    rsp_flag_valid <= issue_has_flag;
                    rsp_err        <= 1'b0;
                    rsp_valid      <= 1'b1;
                    acc_reg        <= alu_result;
                    op_count       <= op_count + 1'b1;
                    state_reg      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready && !cmd_valid) begin
                        rsp_valid <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: ;
            endcase

            // New command, from IDLE or back-to-back with a retiring response.
            if (accept) begin
                if (op_is_legal(cmd_op)) begin
                    alu_a       <= cmd_chain ? acc_reg : cmd_a;
                    alu_b       <= cmd_b;
                    alu_ctrl    <= cmd_op;
                    alu_flag_in <= cmd_flag_in;
                    rsp_valid   <= 1'b0;
                    state_reg   <= S_ISSUE;
                end else begin
                    // Illegal code: answer immediately, leave ALU inputs and acc alone.
                    rsp_result     <= '0;
                    rsp_flag       <= 1'b0;
                    rsp_flag_valid <= 1'b0;
                    rsp_err        <= 1'b1;
                    rsp_valid      <= 1'b1;
                    err_count      <= err_count + 1'b1;
                    state_reg      <= S_RESP;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and a response-queue model.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = '0;
    logic [3:0] cmd_a = '0;
    logic [3:0] cmd_b = '0;
    logic       cmd_flag_in = 1'b0;
    logic       cmd_chain = 1'b0;
    logic [3:0] alu_a, alu_b, alu_ctrl;
    logic       alu_flag_in;
    logic [3:0] alu_result;
    logic       alu_flags;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_result;
    logic       rsp_flag, rsp_flag_valid, rsp_err;
    logic [7:0] op_count, err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.ANCHO(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_flag_in(cmd_flag_in), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_flag_in(alu_flag_in),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flag(rsp_flag), .rsp_flag_valid(rsp_flag_valid), .rsp_err(rsp_err),
        .op_count(op_count), .err_count(err_count)
    );

    // Reference ALU: {flag, result}. Ops without a defined flag drive flag=1 on purpose.
    function automatic logic [4:0] alu_fn(input logic [3:0] op, input logic [3:0] a,
                                          input logic [3:0] b, input logic fi);
        case (op)
            4'd0: return {1'b1, a & b};
            4'd1: return {1'b1, a | b};
            4'd2: return {1'b0, a} + {1'b0, b} + {4'b0, fi};
            4'd3: return {1'b1, ~(a & b)};
            4'd4: return {1'b1, ~(a | b)};
            4'd5: return {1'b1, ~a};
            4'd6: return {1'b0, a} - {1'b0, b} - {4'b0, fi};
            4'd7: return {1'b1, a ^ b};
            4'd8: return {a[3], a[2:0], 1'b0};
            4'd9: return {a[0], 1'b0, a[3:1]};
            default: return 5'd0;
        endcase
    endfunction

    always_comb {alu_flags, alu_result} = alu_fn(alu_ctrl, alu_a, alu_b, alu_flag_in);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [3:0] res;
        logic       flag;
        logic       fv;
        logic       err;
        logic [7:0] ops;
        logic [7:0] errs;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] m_acc = '0;
    logic [7:0] m_ops = '0;
    logic [7:0] m_errs = '0;
    logic [3:0] m_alu_a = '0, m_alu_b = '0, m_alu_ctrl = '0;
    logic       m_alu_fi = 1'b0;

    // Compare process: checks every output on every falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_acc = '0; m_ops = '0; m_errs = '0;
            m_alu_a = '0; m_alu_b = '0; m_alu_ctrl = '0; m_alu_fi = 1'b0;
            chk("rst_alu", 32'({alu_a, alu_b, alu_ctrl, alu_flag_in}), 32'd0);
            chk("rst_rsp", 32'({rsp_valid, rsp_result, rsp_flag, rsp_flag_valid, rsp_err, cmd_ready}), 32'd0);
            chk("rst_cnt", 32'({op_count, err_count}), 32'd0);
        end else begin
            chk("alu_inputs", 32'({alu_a, alu_b, alu_ctrl, alu_flag_in}),
                32'({m_alu_a, m_alu_b, m_alu_ctrl, m_alu_fi}));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    chk("rsp_fields", 32'({rsp_result, rsp_flag, rsp_flag_valid, rsp_err}),
                        32'({exp_q[0].res, exp_q[0].flag, exp_q[0].fv, exp_q[0].err}));
                    chk("rsp_counters", 32'({op_count, err_count}),
                        32'({exp_q[0].ops, exp_q[0].errs}));
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
            if (cmd_valid && cmd_ready) begin
                exp_t e;
                if (cmd_op <= 4'd9) begin
                    logic [3:0] a_eff;
                    logic [4:0] r;
                    a_eff = cmd_chain ? m_acc : cmd_a;
                    r = alu_fn(cmd_op, a_eff, cmd_b, cmd_flag_in);
                    m_ops = m_ops + 8'd1;
                    e.res = r[3:0];
                    e.fv = (cmd_op == 4'd2) || (cmd_op == 4'd6) || (cmd_op == 4'd8) || (cmd_op == 4'd9);
                    e.flag = r[4] & e.fv;
                    e.err = 1'b0;
                    m_acc = r[3:0];
                    m_alu_a = a_eff; m_alu_b = cmd_b; m_alu_ctrl = cmd_op; m_alu_fi = cmd_flag_in;
                end else begin
                    m_errs = m_errs + 8'd1;
                    e.res = '0; e.flag = 1'b0; e.fv = 1'b0; e.err = 1'b1;
                end
                e.ops = m_ops;
                e.errs = m_errs;
                exp_q.push_back(e);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // One command with literal expectations; response held for 'hold' cycles before retiring.
    task automatic run_cmd(input string name, input logic [3:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic fi, input logic chain,
                           input logic [3:0] e_res, input logic e_flag, input logic e_fv,
                           input logic e_err, input int e_lat, input int hold);
        int n;
        @(posedge clk); #1;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_flag_in = fi; cmd_chain = chain;
        cmd_valid = 1'b1; rsp_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 20);
        chk({name, "_accept"}, 32'(cmd_ready), 32'd1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk); n = 1;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk({name, "_latency"}, 32'(n), 32'(e_lat));
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            chk({name, "_rsp"}, 32'({rsp_valid, rsp_result, rsp_flag, rsp_flag_valid, rsp_err}),
                32'({1'b1, e_res, e_flag, e_fv, e_err}));
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        $display("cmd %s op=%0h a=%0h b=%0h chain=%0b -> res=%0h flag=%0b fv=%0b err=%0b lat=%0d",
                 name, op, a, b, chain, e_res, e_flag, e_fv, e_err, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'({cmd_ready, rsp_valid}), 32'b10);

        run_cmd("and",  4'h0, 4'hC, 4'hA, 1'b0, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 2, 0);
        chk("op_count_and", 32'(op_count), 32'd1);
        run_cmd("add",  4'h2, 4'h9, 4'h8, 1'b0, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 2, 0);
        run_cmd("xor",  4'h7, 4'h5, 4'h3, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 2, 0);
        run_cmd("orch", 4'h1, 4'h0, 4'h8, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 2, 0);
        chk("chain_alu_a", 32'(alu_a), 32'h6);
        run_cmd("ill",  4'hB, 4'hF, 4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1, 2);
        chk("ill_counts", 32'({op_count, err_count}), 32'h0401);
        chk("ill_alu_a_held", 32'({alu_a, alu_ctrl}), 32'h61);
        run_cmd("orch2", 4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 2, 0);
        run_cmd("sub",  4'h6, 4'h3, 4'h5, 1'b0, 1'b0, 4'hE, 1'b1, 1'b1, 1'b0, 2, 0);
        run_cmd("lsh",  4'h8, 4'h9, 4'h0, 1'b0, 1'b0, 4'h2, 1'b1, 1'b1, 1'b0, 2, 0);
        run_cmd("rsh",  4'h9, 4'h4, 4'h0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b1, 1'b0, 2, 0);
        run_cmd("not",  4'h5, 4'h3, 4'h0, 1'b0, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 2, 0);
        chk("op_count_9", 32'(op_count), 32'd9);

        // Backpressure with a queued command, then same-cycle retire/accept.
        @(posedge clk); #1;
        cmd_op = 4'h2; cmd_a = 4'h7; cmd_b = 4'h7; cmd_flag_in = 1'b1; cmd_chain = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_op = 4'h7; cmd_a = 4'hF; cmd_b = 4'h0; cmd_flag_in = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_hold", 32'({cmd_ready, rsp_valid, rsp_result, rsp_flag, rsp_flag_valid}),
                32'({1'b0, 1'b1, 4'hF, 1'b0, 1'b1}));
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_same_cycle_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1 rsp_ready = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        chk("bp_issue_gap", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("bp_next_rsp", 32'({rsp_valid, rsp_result, rsp_flag_valid}), 32'({1'b1, 4'hF, 1'b0}));
        $display("cmd bp add 7+7+1 held 5 cycles then xor accepted back-to-back");
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        chk("op_count_11", 32'(op_count), 32'd11);

        // Reset while the command is in ISSUE.
        @(posedge clk); #1;
        cmd_op = 4'h2; cmd_a = 4'h1; cmd_b = 4'h1; cmd_flag_in = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_issue_alu", 32'({alu_a, alu_b, alu_ctrl}), 32'd0);
        chk("rst_mid_issue_rsp", 32'({rsp_valid, rsp_result, cmd_ready, op_count, err_count}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        end
        $display("cmd reset during issue: response dropped");
        run_cmd("and2", 4'h0, 4'hF, 4'h3, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 2, 0);
        chk("op_count_after_rst", 32'(op_count), 32'd1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
